transconv_requant: RTL and testbench
====================================

Name: transconv_requant

Overview:
Downstream stage of transconv. Accepts the 20-bit signed accumulator pixel stream and requantizes each pixel to int8. Requantization is a rounding arithmetic shift, optional ReLU, then saturation. Results are buffered in a small FIFO and presented on a valid/ready output with row and frame markers for the next layer's line buffers. Provides backpressure so the controller can stall transconv write-out (rw low) phases.

Parameters:
IN_W, 20, accumulator width from transconv
OUT_W, 8, requantized pixel width (signed)
FRAME_WIDTH, 8, output pixels per row (2x upsampled width)
FRAME_HEIGHT, 8, output rows per frame
FIFO_DEPTH, 16, output buffer entries (power of 2, >=4)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  in_pixel valid this cycle
in_pixel  in  IN_W  signed accumulator pixel
in_ready  out  1  stage can accept; transfer when in_valid && in_ready
shift  in  5  right-shift amount, sampled with each accepted pixel
relu_en  in  1  clamp negatives to 0, sampled with each accepted pixel
out_valid  out  1  out_pixel valid
out_ready  in  1  consumer accepts; pop when out_valid && out_ready
out_pixel  out  OUT_W  signed requantized pixel
out_last_col  out  1  out_pixel is the last pixel of its row
out_last_frame  out  1  out_pixel is the last pixel of the frame
frame_done  out  1  one-cycle pulse, cycle after the last frame pixel pops
sat_count  out  16  saturation event counter (see Optional Feature)

Behaviour:
- Reset (rst low, asynchronous):
  - in_ready=0 while rst is held low.
  - out_valid=0, out_pixel=0, out_last_col=0, out_last_frame=0, frame_done=0, sat_count=0.
  - FIFO is emptied, pipeline valids cleared, col/row counters set to 0.
  - Reset mid-frame discards all in-flight and buffered pixels. The next frame starts at col 0, row 0.
- Stage 1, registered on accept:
  - Effective shift s = min(shift, IN_W-1).
  - If s>0: r = (in_pixel + (1<<(s-1))) >>> s. If s=0: r = in_pixel.
  - The addition is done at IN_W+1 bits, so there is no overflow.
  - Rounding is round-half-up (toward +inf).
- Stage 2, registered:
  - If relu_en (as captured) and r<0, then v=0.
  - Saturate v to [-128,127].
  - A saturation event is a clip to either bound. ReLU clamping is not a saturation event.
- FIFO write at end of stage 2. out_valid follows on the next cycle.
- Latency: accepted input to out_valid is 3 cycles when the FIFO is empty.
- Throughput: 1 pixel/cycle when out_ready is held high.
- in_ready = (fifo_count + s1_valid + s2_valid) < FIFO_DEPTH. This is combinational from registered state only, with no dependence on in_valid.
- The FIFO never overflows; writes are guaranteed accepted.
- Empty FIFO: out_valid=0. out_pixel holds its last value.
- Simultaneous push and pop at full or empty: count is unchanged and data is ordered correctly.
- out_pixel, out_last_col and out_last_frame stay stable while out_valid && !out_ready.
- Output position counters col/row advance only on the pop handshake:
  - col wraps at FRAME_WIDTH-1 and increments row.
  - row wraps at FRAME_HEIGHT-1 back to 0.
  - out_last_col = (col==FRAME_WIDTH-1).
  - out_last_frame = out_last_col && (row==FRAME_HEIGHT-1).
  - Both flags are valid only with out_valid.
- frame_done pulses one cycle after the pop of the out_last_frame pixel.
- shift and relu_en may change every cycle. Each pixel uses the values present at its own acceptance.

Optional Feature:
Macro REQUANT_SAT_CNT_EN.
- Defined: sat_count increments on every stage-2 saturation event.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: no counter logic. sat_count is tied to 0.

Decomposition:
- Package unet_accel_pkg:
  - ACC_W=20, PIX_W=8
  - PIX_MAX=127, PIX_MIN=-128
  - SHIFT_W=5
  - shared by transconv, conv and this block
- One sub-module: sync_fifo (parameterized width/depth, count output, registered read data).
  - Instantiated with width OUT_W.
  - The last-col/frame flags are computed at the output, not stored.

Test Plan:
1. shift=0, relu_en=0, out_ready=1; inputs 100, -3, 546, -8100 -> outputs 100, -3, 127, -128. sat_count=2 with the macro defined, 0 without.
2. shift=4; inputs 1134, -38, 8 -> outputs 71, -2, 1 (round half up). shift=25; input 1100 -> clamped to s=19, output 0.
3. relu_en=1, shift=0; inputs -3800, 81, -1 -> outputs 0, 81, 0. sat_count unchanged.
4. out_ready=0, in_valid=1 continuously -> exactly 16 pixels accepted, then in_ready=0. Raise out_ready -> all 16 pop in order with no loss or duplicate, and in_ready reasserts.
5. Full 8x8 frame of 64 pixels with random out_ready -> out_last_col on pops 8, 16, ..., 64; out_last_frame only on pop 64; one frame_done pulse. A second frame restarts at col 0.
6. Assert rst low after 20 pixels are accepted -> all outputs return to reset values immediately. After release, the next frame's first pop has col 0 and no stale data appears.

Source files
------------

// File: rtl/unet_accel_pkg.sv
// unet_accel_pkg: widths and int8 pixel bounds shared by transconv, conv and transconv_requant.
package unet_accel_pkg;
    localparam int ACC_W   = 20;
    localparam int PIX_W   = 8;
    localparam int SHIFT_W = 5;
    localparam int PIX_MAX = 127;
    localparam int PIX_MIN = -128;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count and a registered, show-ahead head word.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rptr_n;
    logic [AW:0] remain;
    assign rptr_n = rptr + AW'(pop);
    assign remain = count - (AW+1)'(pop);
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end
    // rdata always holds the word at the head after this cycle; a push into an empty queue bypasses mem
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rdata <= '0;
        end else begin
            wptr  <= wptr + AW'(push);
            rptr  <= rptr_n;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            rdata <= remain == '0 ? (push ? wdata : rdata) : mem[rptr_n];
        end
    end
endmodule

// File: rtl/transconv_requant.sv
// transconv_requant: rounding shift, optional ReLU and int8 saturation of the transconv pixel stream.
// Define REQUANT_SAT_CNT_EN to build the saturation event counter; otherwise sat_count is 0.
module transconv_requant
    import unet_accel_pkg::*;
#(
    parameter int IN_W         = ACC_W,
    parameter int OUT_W        = PIX_W,
    parameter int FRAME_WIDTH  = 8,
    parameter int FRAME_HEIGHT = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_pixel,
    output logic                    in_ready,
    input  logic [SHIFT_W-1:0]      shift,
    input  logic                    relu_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_pixel,
    output logic                    out_last_col,
    output logic                    out_last_frame,
    output logic                    frame_done,
    output logic [15:0]             sat_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int CL = $clog2(FRAME_WIDTH);
    localparam int RL = $clog2(FRAME_HEIGHT);
    localparam logic signed [IN_W:0] HI = (IN_W+1)'(PIX_MAX);
    localparam logic signed [IN_W:0] LO = (IN_W+1)'(PIX_MIN);
    localparam logic [SHIFT_W-1:0] SMAX = SHIFT_W'(IN_W - 1);

    logic [SHIFT_W-1:0] s;
    logic signed [IN_W:0] ext, rnd, r_next, s1_r, v;
    logic signed [OUT_W-1:0] s2_pix;
    logic s1_valid, s1_relu, s2_valid, accept, pop, sat_hi, sat_lo;
    logic [CW-1:0] count;
    logic [CL-1:0] col;
    logic [RL-1:0] row;

    // one extra bit of headroom keeps the rounding add from overflowing
    always_comb begin
        s      = shift > SMAX ? SMAX : shift;
        ext    = {in_pixel[IN_W-1], in_pixel};
        rnd    = s == '0 ? '0 : (IN_W+1)'(1) << (s - 1'b1);
        r_next = (ext + rnd) >>> s;
        v      = s1_relu && s1_r[IN_W] ? '0 : s1_r;
        sat_hi = v > HI;
        sat_lo = v < LO;
    end

    assign in_ready       = rst && (32'(count) + 32'(s1_valid) + 32'(s2_valid) < FIFO_DEPTH);
    assign accept         = in_valid && in_ready;
    assign out_valid      = count != '0;
    assign pop            = out_valid && out_ready;
    assign out_last_col   = col == CL'(FRAME_WIDTH - 1);
    assign out_last_frame = out_last_col && row == RL'(FRAME_HEIGHT - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s1_r       <= '0;
            s1_relu    <= 1'b0;
            s2_valid   <= 1'b0;
            s2_pix     <= '0;
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_r    <= r_next;
                s1_relu <= relu_en;
            end
            s2_valid <= s1_valid;
            if (s1_valid) s2_pix <= sat_hi ? OUT_W'(PIX_MAX) : sat_lo ? OUT_W'(PIX_MIN) : v[OUT_W-1:0];
            if (pop) begin
                col <= out_last_col ? '0 : col + 1'b1;
                if (out_last_col) row <= out_last_frame ? '0 : row + 1'b1;
            end
            frame_done <= pop && out_last_frame;
        end
    end

`ifdef REQUANT_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sat_count <= '0;
        else if (s1_valid && (sat_hi || sat_lo) && sat_count != 16'hFFFF) sat_count <= sat_count + 1'b1;
    end
`else
    assign sat_count = '0;
`endif

    sync_fifo #(.WIDTH(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_valid),
        .wdata (s2_pix),
        .pop   (pop),
        .rdata (out_pixel),
        .count (count)
    );
endmodule

// File: tb/tb_transconv_requant.sv
// tb_transconv_requant: directed checks of requantization, backpressure, frame markers and reset.
module tb_transconv_requant;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, relu_en = 1'b0, out_ready = 1'b0;
    logic signed [19:0] in_pixel = '0;
    logic [4:0] shift = '0;
    logic in_ready, out_valid, out_last_col, out_last_frame, frame_done;
    logic signed [7:0] out_pixel;
    logic [15:0] sat_count;
    int errors = 0, checks = 0, fd_cnt = 0;
    logic signed [7:0] q_pix[$];
    bit q_lc[$], q_lf[$];
    logic [15:0] exp_sat;

    transconv_requant dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready),
        .shift(shift), .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_last_col(out_last_col), .out_last_frame(out_last_frame),
        .frame_done(frame_done), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    // inputs change on negedge; values seen 2 units later are what the next posedge uses
    always begin
        @(negedge clk);
        #2;
        if (rst && out_valid && out_ready) begin
            q_pix.push_back(out_pixel);
            q_lc.push_back(out_last_col);
            q_lf.push_back(out_last_frame);
        end
        if (rst && frame_done) fd_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send(input logic signed [19:0] p, input logic [4:0] sh, input logic r);
        int n = 0;
        in_valid = 1'b1; in_pixel = p; shift = sh; relu_en = r;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (!in_ready) begin errors++; $display("FAIL send_timeout: in_ready=%b required 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic clr();
        q_pix.delete(); q_lc.delete(); q_lf.delete();
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks += 7;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (out_pixel !== 8'sd0) begin errors++; $display("FAIL rst_out_pixel: got %0d want 0", out_pixel); end
        if (out_last_col !== 1'b0) begin errors++; $display("FAIL rst_last_col: got %b want 0", out_last_col); end
        if (out_last_frame !== 1'b0) begin errors++; $display("FAIL rst_last_frame: got %b want 0", out_last_frame); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        if (sat_count !== 16'd0) begin errors++; $display("FAIL rst_sat_count: got %0d want 0", sat_count); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_saturate();
        logic signed [7:0] e[4] = '{8'sd100, -8'sd3, 8'sd127, -8'sd128};
        clr(); out_ready = 1'b1;
        send(100, 0, 0); send(-3, 0, 0); send(546, 0, 0); send(-8100, 0, 0);
        repeat (8) @(negedge clk);
        checks++;
        if (q_pix.size() != 4) begin errors++; $display("FAIL sat_count_pops: got %0d want 4", q_pix.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_pix[i] !== e[i]) begin errors++; $display("FAIL sat_pix[%0d]: got %0d want %0d", i, q_pix[i], e[i]); end
        end
`ifdef REQUANT_SAT_CNT_EN
        exp_sat = 16'd2;
`else
        exp_sat = 16'd0;
`endif
        checks++;
        if (sat_count !== exp_sat) begin errors++; $display("FAIL sat_counter: got %0d want %0d", sat_count, exp_sat); end
    endtask

    task automatic test_round();
        logic signed [7:0] e[4] = '{8'sd71, -8'sd2, 8'sd1, 8'sd0};
        clr();
        send(1134, 4, 0); send(-38, 4, 0); send(8, 4, 0); send(1100, 25, 0);
        repeat (8) @(negedge clk);
        checks++;
        if (q_pix.size() != 4) begin errors++; $display("FAIL round_pops: got %0d want 4", q_pix.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_pix[i] !== e[i]) begin errors++; $display("FAIL round_pix[%0d]: got %0d want %0d", i, q_pix[i], e[i]); end
        end
    endtask

    task automatic test_relu();
        logic signed [7:0] e[3] = '{8'sd0, 8'sd81, 8'sd0};
        clr();
        send(-3800, 0, 1); send(81, 0, 1); send(-1, 0, 1);
        repeat (8) @(negedge clk);
        checks++;
        if (q_pix.size() != 3) begin errors++; $display("FAIL relu_pops: got %0d want 3", q_pix.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (q_pix[i] !== e[i]) begin errors++; $display("FAIL relu_pix[%0d]: got %0d want %0d", i, q_pix[i], e[i]); end
        end
        checks++;
        if (sat_count !== exp_sat) begin errors++; $display("FAIL relu_sat_counter: got %0d want %0d", sat_count, exp_sat); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        logic rdy;
        out_ready = 1'b0; shift = '0; relu_en = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            in_pixel = 20'(acc * 3);
            rdy = in_ready;
            @(negedge clk);
            if (rdy) acc++;
        end
        in_valid = 1'b0;
        checks += 3;
        if (acc != 16) begin errors++; $display("FAIL bp_accepted: got %0d want 16", acc); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        clr(); out_ready = 1'b1;
        repeat (25) @(negedge clk);
        checks++;
        if (q_pix.size() != 16) begin errors++; $display("FAIL bp_pops: got %0d want 16", q_pix.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (q_pix[i] !== 8'(i * 3)) begin errors++; $display("FAIL bp_pix[%0d]: got %0d want %0d", i, q_pix[i], i * 3); end
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_drained: got %b want 1", in_ready); end
    endtask

    task automatic test_frame();
        pulse_reset();
        clr(); fd_cnt = 0;
        fork
            for (int i = 0; i < 64; i++) send(20'(i), 0, 0);
            begin
                for (int k = 0; k < 150; k++) begin out_ready = 1'($urandom_range(0, 1)); @(negedge clk); end
                out_ready = 1'b1;
            end
        join
        repeat (30) @(negedge clk);
        checks += 2;
        if (q_pix.size() != 64) begin errors++; $display("FAIL frame_pops: got %0d want 64", q_pix.size()); end
        if (fd_cnt != 1) begin errors++; $display("FAIL frame_done_pulses: got %0d want 1", fd_cnt); end
        for (int i = 0; i < 64; i++) begin
            checks += 3;
            if (q_pix[i] !== 8'(i)) begin errors++; $display("FAIL frame_pix[%0d]: got %0d want %0d", i, q_pix[i], i); end
            if (q_lc[i] != (i % 8 == 7)) begin errors++; $display("FAIL frame_last_col[%0d]: got %b want %b", i, q_lc[i], i % 8 == 7); end
            if (q_lf[i] != (i == 63)) begin errors++; $display("FAIL frame_last_frame[%0d]: got %b want %b", i, q_lf[i], i == 63); end
        end
        clr();
        for (int i = 0; i < 8; i++) send(20'(i + 10), 0, 0);
        repeat (10) @(negedge clk);
        checks++;
        if (q_pix.size() != 8) begin errors++; $display("FAIL frame2_pops: got %0d want 8", q_pix.size()); end
        for (int i = 0; i < 8; i++) begin
            checks += 3;
            if (q_pix[i] !== 8'(i + 10)) begin errors++; $display("FAIL frame2_pix[%0d]: got %0d want %0d", i, q_pix[i], i + 10); end
            if (q_lc[i] != (i == 7)) begin errors++; $display("FAIL frame2_last_col[%0d]: got %b want %b", i, q_lc[i], i == 7); end
            if (q_lf[i] != 1'b0) begin errors++; $display("FAIL frame2_last_frame[%0d]: got %b want 0", i, q_lf[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        pulse_reset();
        out_ready = 1'b1;
        send(5000, 0, 0);
        for (int i = 1; i < 20; i++) send(20'(50 + i), 0, 0);
`ifdef REQUANT_SAT_CNT_EN
        checks++;
        if (sat_count !== 16'd1) begin errors++; $display("FAIL mid_sat_before: got %0d want 1", sat_count); end
`endif
        rst = 1'b0;
        #1;
        checks += 7;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        if (out_pixel !== 8'sd0) begin errors++; $display("FAIL mid_out_pixel: got %0d want 0", out_pixel); end
        if (out_last_col !== 1'b0) begin errors++; $display("FAIL mid_last_col: got %b want 0", out_last_col); end
        if (out_last_frame !== 1'b0) begin errors++; $display("FAIL mid_last_frame: got %b want 0", out_last_frame); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_frame_done: got %b want 0", frame_done); end
        if (sat_count !== 16'd0) begin errors++; $display("FAIL mid_sat_count: got %0d want 0", sat_count); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clr();
        for (int i = 0; i < 8; i++) send(20'(i + 1), 0, 0);
        repeat (10) @(negedge clk);
        checks++;
        if (q_pix.size() != 8) begin errors++; $display("FAIL mid_pops: got %0d want 8", q_pix.size()); end
        for (int i = 0; i < 8; i++) begin
            checks += 2;
            if (q_pix[i] !== 8'(i + 1)) begin errors++; $display("FAIL mid_pix[%0d]: got %0d want %0d", i, q_pix[i], i + 1); end
            if (q_lc[i] != (i == 7)) begin errors++; $display("FAIL mid_last_col[%0d]: got %b want %b", i, q_lc[i], i == 7); end
        end
    endtask

    initial begin
        test_reset();
        test_saturate();
        test_round();
        test_relu();
        test_backpressure();
        test_frame();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
